// File: rtl/seg7_passcode.sv
// IR-remote passcode checker with a 7-segment display.
// Optional macro PASS_REVEAL_EN shows the entered digits in clear during entry.
module seg7_passcode #(
    parameter int DIGITS      = 4,
    parameter int MATCH_MIN   = DIGITS,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  key_valid,
    input  logic [7:0]            key_code,
    input  logic [4*DIGITS-1:0]   code_ref,
    output logic [7*DIGITS-1:0]   hex_seg,
    output logic [1:0]            check_pass,
    output logic                  locked,
    output logic [3:0]            fail_cnt,
    output logic [2:0]            state_dbg
);

    // key_valid is a one-cycle strobe with no back-pressure: every key is
    // consumed (acted on or dropped) on the rising edge where it is high.
    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_GRANTED = 3'd1,
        ST_DENIED  = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_ARMED   = 3'd4
    } state_t;

    localparam int LCW = $clog2(LOCK_CYCLES);
    localparam logic [LCW-1:0] LOCK_LOAD = LCW'(LOCK_CYCLES - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MASK  = 7'b0000000;
    localparam logic [6:0] SEG_LOCK  = 7'b0111111;
    localparam logic [6:0] SEG_ARMED = 7'b0001000;

    state_t                state_q, state_d;
    logic [3:0]            count_q, count_d;
    logic [4*DIGITS-1:0]   dig_q, dig_d;
    logic [1:0]            cp_q, cp_d;
    logic                  locked_q, locked_d;
    logic [3:0]            fail_q, fail_d;
    logic [LCW-1:0]        lock_q, lock_d;
    logic [7*DIGITS-1:0]   hex_q, hex_d;
    logic [3:0]            match_cnt;

    logic is_digit, is_enter, is_bksp, is_arm;
    assign is_digit = key_valid && (key_code < 8'h0A);
    assign is_enter = key_valid && (key_code == 8'h1A);
    assign is_bksp  = key_valid && (key_code == 8'h1E);
    assign is_arm   = key_valid && (key_code == 8'h16);

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0011000;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        match_cnt = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_q[4*k +: 4] == code_ref[4*k +: 4]) match_cnt = match_cnt + 4'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        dig_d    = dig_q;
        cp_d     = cp_q;
        locked_d = locked_q;
        fail_d   = fail_q;
        lock_d   = lock_q;
        case (state_q)
            ST_ENTRY: begin
                if (is_digit && (count_q < 4'(DIGITS))) begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (k == int'(count_q)) dig_d[4*k +: 4] = key_code[3:0];
                    end
                    count_d = count_q + 4'd1;
                    cp_d    = 2'b00;
                end else if (is_bksp && (count_q != 4'd0)) begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (k == int'(count_q) - 1) dig_d[4*k +: 4] = 4'd0;
                    end
                    count_d = count_q - 4'd1;
                end else if (is_enter && (count_q == 4'(DIGITS))) begin
                    if (match_cnt >= 4'(MATCH_MIN)) begin
                        state_d = ST_GRANTED;
                        fail_d  = 4'd0;
                        cp_d    = 2'b01;
                    end else begin
                        state_d = ST_DENIED;
                        cp_d    = 2'b10;
                        fail_d  = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;
                    end
                end
            end
            ST_GRANTED: begin
                if (is_arm) begin
                    state_d = ST_ARMED;
                    cp_d    = 2'b11;
                end else if (is_bksp) begin
                    state_d = ST_ENTRY;
                    count_d = 4'd0;
                    dig_d   = '0;
                    cp_d    = 2'b00;
                end
            end
            ST_DENIED: begin
                count_d = 4'd0;
                dig_d   = '0;
                if (fail_q >= 4'(MAX_FAIL)) begin
                    state_d  = ST_LOCKED;
                    locked_d = 1'b1;
                    lock_d   = LOCK_LOAD;
                end else begin
                    state_d = ST_ENTRY;
                end
            end
            ST_LOCKED: begin
                if (lock_q == '0) begin
                    state_d  = ST_ENTRY;
                    locked_d = 1'b0;
                    fail_d   = 4'd0;
                    cp_d     = 2'b00;
                end else begin
                    lock_d = lock_q - 1'b1;
                end
            end
            ST_ARMED: ;
            default: state_d = ST_ENTRY;
        endcase
        // Disabling remote entry aborts anything but a running lockout.
        if (!enable && (state_q != ST_LOCKED)) begin
            state_d = ST_ENTRY;
            count_d = 4'd0;
            dig_d   = '0;
            cp_d    = 2'b00;
        end
    end

    // Display is derived from next-state values so it changes with the state.
    always_comb begin
        hex_d = '1;
        for (int k = 0; k < DIGITS; k++) begin
            case (state_d)
                ST_GRANTED: hex_d[7*k +: 7] = glyph(dig_d[4*k +: 4]);
                ST_LOCKED:  hex_d[7*k +: 7] = SEG_LOCK;
                ST_ARMED:   hex_d[7*k +: 7] = SEG_ARMED;
                default: begin
                    if (k < int'(count_d)) begin
`ifdef PASS_REVEAL_EN
                        hex_d[7*k +: 7] = glyph(dig_d[4*k +: 4]);
`else
                        hex_d[7*k +: 7] = SEG_MASK;
`endif
                    end else begin
                        hex_d[7*k +: 7] = SEG_BLANK;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_ENTRY;
            count_q  <= 4'd0;
            dig_q    <= '0;
            cp_q     <= 2'b00;
            locked_q <= 1'b0;
            fail_q   <= 4'd0;
            lock_q   <= '0;
            hex_q    <= '1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            dig_q    <= dig_d;
            cp_q     <= cp_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
            lock_q   <= lock_d;
            hex_q    <= hex_d;
        end
    end

    assign hex_seg    = hex_q;
    assign check_pass = cp_q;
    assign locked     = locked_q;
    assign fail_cnt   = fail_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_seg7_passcode.sv
// Self-checking bench for seg7_passcode: keys are driven with their expected
// post-edge observation queued, then popped and compared after the edge.
module tb_seg7_passcode;

    localparam int DIGITS      = 4;
    localparam int MATCH_MIN   = 3;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYCLES = 16;
    localparam int OW          = 3 + 2 + 1 + 4 + 7*DIGITS;

    localparam logic [2:0] S_E = 3'd0, S_G = 3'd1, S_D = 3'd2, S_L = 3'd3, S_A = 3'd4;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  enable = 1'b1;
    logic                  key_valid = 1'b0;
    logic [7:0]            key_code = 8'h00;
    logic [4*DIGITS-1:0]   code_ref = 16'h1452;
    logic [7*DIGITS-1:0]   hex_seg;
    logic [1:0]            check_pass;
    logic                  locked;
    logic [3:0]            fail_cnt;
    logic [2:0]            state_dbg;

    logic [OW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    seg7_passcode #(
        .DIGITS(DIGITS), .MATCH_MIN(MATCH_MIN), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .key_valid(key_valid),
        .key_code(key_code), .code_ref(code_ref), .hex_seg(hex_seg),
        .check_pass(check_pass), .locked(locked), .fail_cnt(fail_cnt), .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0011000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] hx_entry(input int n);
        logic [7*DIGITS-1:0] h;
        for (int k = 0; k < DIGITS; k++) h[7*k +: 7] = (k < n) ? 7'b0000000 : 7'b1111111;
        return h;
    endfunction

    function automatic logic [7*DIGITS-1:0] hx_all(input logic [6:0] g);
        return {DIGITS{g}};
    endfunction

    function automatic logic [7*DIGITS-1:0] hx_dig(input int d0, input int d1, input int d2, input int d3);
        return {glyph(d3), glyph(d2), glyph(d1), glyph(d0)};
    endfunction

    function automatic logic [OW-1:0] mk(input logic [2:0] st, input logic [1:0] cp, input logic lk,
                                         input logic [3:0] fc, input logic [7*DIGITS-1:0] hx);
        return {st, cp, lk, fc, hx};
    endfunction

    // scoreboard
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample_check(input string tag);
        logic [OW-1:0] e;
        e = exp_q.pop_front();
        check(tag, 64'({state_dbg, check_pass, locked, fail_cnt, hex_seg}), 64'(e));
    endtask

    // drivers (called right after a falling edge)
    task automatic send(input string tag, input logic [7:0] k, input logic [OW-1:0] e);
        exp_q.push_back(e);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = $urandom_range(8'h40, 8'hFF);
        sample_check(tag);
    endtask

    task automatic tick(input string tag, input logic [OW-1:0] e);
        exp_q.push_back(e);
        @(negedge clk);
        sample_check(tag);
    endtask

    task automatic expect_now(input string tag, input logic [OW-1:0] e);
        exp_q.push_back(e);
        sample_check(tag);
    endtask

    task automatic type_code(input string tag, input int d0, input int d1, input int d2, input int d3,
                             input logic [3:0] fc);
        int d[4];
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) send(tag, 8'(d[i]), mk(S_E, 2'b00, 1'b0, fc, hx_entry(i + 1)));
    endtask

    task automatic deny_round(input string tag, input logic [3:0] fc_before);
        logic [3:0] fc;
        fc = fc_before + 4'd1;
        type_code(tag, 9, 9, 9, 9, fc_before);
        send({tag, "_enter"}, 8'h1A, mk(S_D, 2'b10, 1'b0, fc, hx_entry(4)));
        if (fc >= 4'(MAX_FAIL)) tick({tag, "_lock"}, mk(S_L, 2'b10, 1'b1, fc, hx_all(7'b0111111)));
        else tick({tag, "_back"}, mk(S_E, 2'b10, 1'b0, fc, hx_entry(0)));
    endtask

    initial begin
        logic [OW-1:0] idle;
        idle = mk(S_E, 2'b00, 1'b0, 4'd0, hx_entry(0));

        // reset
        repeat (2) @(negedge clk);
        expect_now("reset_hold", idle);
        reset_n = 1'b1;
        tick("reset_release", idle);

        // correct code
        type_code("ok_digits", 2, 5, 4, 1, 4'd0);
        send("ok_enter", 8'h1A, mk(S_G, 2'b01, 1'b0, 4'd0, hx_dig(2, 5, 4, 1)));
        send("granted_ignore_digit", 8'h05, mk(S_G, 2'b01, 1'b0, 4'd0, hx_dig(2, 5, 4, 1)));
        send("granted_bksp", 8'h1E, idle);

        // backspace / short enter / full buffer
        send("d1", 8'h01, mk(S_E, 2'b00, 1'b0, 4'd0, hx_entry(1)));
        send("d2", 8'h02, mk(S_E, 2'b00, 1'b0, 4'd0, hx_entry(2)));
        send("bksp_to1", 8'h1E, mk(S_E, 2'b00, 1'b0, 4'd0, hx_entry(1)));
        send("enter_short", 8'h1A, mk(S_E, 2'b00, 1'b0, 4'd0, hx_entry(1)));
        send("bksp_to0", 8'h1E, idle);
        send("bksp_at0", 8'h1E, idle);
        send("bad_code", 8'h33, idle);
        type_code("fill", 9, 9, 9, 9, 4'd0);
        send("fifth_digit", 8'h09, mk(S_E, 2'b00, 1'b0, 4'd0, hx_entry(4)));
        send("deny1_enter", 8'h1A, mk(S_D, 2'b10, 1'b0, 4'd1, hx_entry(4)));
        tick("deny1_back", mk(S_E, 2'b10, 1'b0, 4'd1, hx_entry(0)));
        tick("deny1_persist", mk(S_E, 2'b10, 1'b0, 4'd1, hx_entry(0)));

        // second denial, then two-match code one below MATCH_MIN triggers lockout
        deny_round("deny2", 4'd1);
        type_code("two_match", 2, 5, 9, 9, 4'd2);
        send("deny3_enter", 8'h1A, mk(S_D, 2'b10, 1'b0, 4'd3, hx_entry(4)));
        tick("lock_enter", mk(S_L, 2'b10, 1'b1, 4'd3, hx_all(7'b0111111)));
        send("lock_ignore_key", 8'h02, mk(S_L, 2'b10, 1'b1, 4'd3, hx_all(7'b0111111)));
        for (int i = 2; i < LOCK_CYCLES; i++)
            tick("lock_hold", mk(S_L, 2'b10, 1'b1, 4'd3, hx_all(7'b0111111)));
        tick("lock_exit", idle);

        // partial match grant, arm, disable
        type_code("near_digits", 2, 5, 4, 9, 4'd0);
        send("near_enter", 8'h1A, mk(S_G, 2'b01, 1'b0, 4'd0, hx_dig(2, 5, 4, 9)));
        send("arm", 8'h16, mk(S_A, 2'b11, 1'b0, 4'd0, hx_all(7'b0001000)));
        send("armed_ignore_bksp", 8'h1E, mk(S_A, 2'b11, 1'b0, 4'd0, hx_all(7'b0001000)));
        enable = 1'b0;
        tick("armed_disable", idle);
        enable = 1'b1;

        // lockout again, disable does not stop it, reset does
        deny_round("r1", 4'd0);
        deny_round("r2", 4'd1);
        deny_round("r3", 4'd2);
        enable = 1'b0;
        tick("lock_disable", mk(S_L, 2'b10, 1'b1, 4'd3, hx_all(7'b0111111)));
        enable = 1'b1;
        tick("lock_again", mk(S_L, 2'b10, 1'b1, 4'd3, hx_all(7'b0111111)));
        #2 reset_n = 1'b0;
        #1 expect_now("async_reset", idle);
        @(negedge clk);
        reset_n = 1'b1;
        tick("after_reset", idle);
        send("resume", 8'h07, mk(S_E, 2'b00, 1'b0, 4'd0, hx_entry(1)));

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_passcode.md
SEG7_PASSCODE -- requirements
Module: seg7_passcode

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning passcode length in digits (legal range 1..8).
REQ-002 SHALL have parameter MATCH_MIN, default DIGITS, meaning the minimum count of matching digit positions that grants access (legal range 1..DIGITS).
REQ-003 SHALL have parameter MAX_FAIL, default 3, meaning the consecutive denials that trigger lockout (legal range 1..15).
REQ-004 SHALL have parameter LOCK_CYCLES, default 1024, meaning lockout duration in clk cycles (legal value at least 2).
REQ-005 SHALL have port clk, input, 1 bit, meaning the system clock; all logic is on the rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1 bit, meaning remote-entry enable; when low, entry is held cleared.
REQ-008 SHALL have port key_valid, input, 1 bit, meaning a one-cycle strobe marking a new decoded IR key.
REQ-009 SHALL have port key_code, input, 8 bits, meaning the IR key code: 0x00-0x09 digit, 0x1A enter, 0x1E backspace, 0x16 arm.
REQ-010 SHALL have port code_ref, input, 4*DIGITS bits, meaning the reference code in BCD, digit k at [4k+3:4k].
REQ-011 SHALL have port hex_seg, output, 7*DIGITS bits, meaning active-low 7-segment glyphs, digit k at [7k+6:7k].
REQ-012 SHALL have port check_pass, output, 2 bits, encoded 00 idle/entry, 01 granted, 10 denied, 11 armed.
REQ-013 SHALL have port locked, output, 1 bit, meaning lockout is active.
REQ-014 SHALL have port fail_cnt, output, 4 bits, meaning the consecutive-denial count.

Function
REQ-015 SHALL implement states ENTRY, GRANTED, DENIED, LOCKED and ARMED, registered, with all outputs registered.
REQ-016 In ENTRY, SHALL accept a digit key only when count<DIGITS: store the digit at position count and increment count; a digit key with the buffer full SHALL be ignored.
REQ-017 In ENTRY, backspace SHALL decrement count and blank that position when count>0, and is a no-op when count=0.
REQ-018 In ENTRY, enter with count<DIGITS SHALL be ignored.
REQ-019 In ENTRY, enter with count=DIGITS SHALL compare each position to code_ref and go to GRANTED if matches>=MATCH_MIN, otherwise go to DENIED; the state is updated in the cycle after the key_valid.
REQ-020 On entering GRANTED, SHALL clear fail_cnt and set check_pass=01.
REQ-021 In GRANTED, arm SHALL go to ARMED with check_pass=11, backspace SHALL return to ENTRY with the buffer cleared, and other keys SHALL be ignored.
REQ-022 On entering DENIED, SHALL set check_pass=10 and increment fail_cnt with saturation at 15.
REQ-023 DENIED SHALL last exactly one cycle: go to LOCKED if fail_cnt>=MAX_FAIL, otherwise go to ENTRY with the buffer cleared.
REQ-024 check_pass=10 SHALL persist until the next accepted digit.
REQ-025 On entering LOCKED, SHALL set locked=1 and load the lock counter with LOCK_CYCLES-1.
REQ-026 In LOCKED, SHALL decrement the lock counter every cycle and ignore all keys; at 0, SHALL go to ENTRY with locked=0, fail_cnt=0 and check_pass=00.
REQ-027 ARMED SHALL be left only by reset or enable low.
REQ-028 enable low SHALL force ENTRY with the buffer cleared and check_pass=00 in any state except LOCKED; LOCKED continues its countdown and fail_cnt is retained.
REQ-029 Key codes not listed in REQ-009 SHALL be ignored in every state.
REQ-030 SHALL display each digit position as follows:
- ENTRY: filled positions show 0000000 (masked), empty positions show 1111111.
- GRANTED: true digit glyphs (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000).
- LOCKED: all positions 0111111.
- ARMED: all positions 0001000.

Reset
REQ-031 While reset_n is low, SHALL immediately hold:
- state ENTRY, count 0, buffer cleared;
- hex_seg all ones, check_pass 00, locked 0, fail_cnt 0, lock counter 0.
REQ-032 Reset asserted mid-lockout or mid-entry SHALL discard all progress; operation resumes on the first rising clk edge after release.

Configuration
REQ-033 With macro PASS_REVEAL_EN defined, SHALL show the true digit glyph for each filled position in ENTRY; without it, SHALL show the masked glyph 0000000 per REQ-030; all other behaviour is identical either way.

Verification
REQ-034 SHALL cover: DIGITS=4, code_ref=16'h1452 (positions 0..3 = 2,5,4,1), keys 02,05,04,01,1A -> check_pass=01 and hex_seg[6:0]=0100100.
REQ-035 SHALL cover: wrong code 09,09,09,09,1A three times with MAX_FAIL=3 -> fail_cnt reaches 3, locked=1 for LOCK_CYCLES cycles, then locked=0 and fail_cnt=0.
REQ-036 SHALL cover: keys 01,02,1E,1A -> count=1 and the enter is ignored; five digit keys -> the fifth is ignored and count=4.
REQ-037 SHALL cover: with MATCH_MIN=3, one wrong digit plus 1A -> GRANTED; then 16 -> check_pass=11 and all hex_seg digits 0001000.
REQ-038 SHALL cover: reset_n pulsed low during LOCKED -> locked=0 and fail_cnt=0 asynchronously; enable low in ARMED -> check_pass=00 on the next cycle.
